// File: rtl/load_store_unit_pkg.sv
// Shared types for the core datapath and the load/store unit.
// Includes the access-size and FSM encodings, plus small address-alignment helpers.
package load_store_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_e;

    typedef enum logic [1:0] {PC_INC, PC_BRANCH, PC_JUMP, PC_JALR} pc_op_e;
    typedef enum logic [1:0] {OP_A_REG, OP_A_PC, OP_A_ZERO} op_a_sel_e;
    typedef enum logic [0:0] {OP_B_REG, OP_B_IMM} op_b_sel_e;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_b_sel_e;

    typedef enum logic [1:0] {
        LSU_W = 2'b00,
        LSU_H = 2'b01,
        LSU_B = 2'b10
    } lsu_type_e;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WAIT_GNT    = 2'b01,
        WAIT_RVALID = 2'b10,
        DONE        = 2'b11
    } lsu_state_e;

    function automatic logic lsu_misaligned(lsu_type_e t, logic [1:0] off);
        case (t)
            LSU_W:   return off != 2'b00;
            LSU_H:   return off[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_byte_en(lsu_type_e t, logic [1:0] off);
        case (t)
            LSU_W:   return 4'b1111;
            LSU_H:   return 4'b0011 << off;
            LSU_B:   return 4'b0001 << off;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_rdata_align.sv
// Combinational load alignment: moves the addressed bytes down to bit 0,
// then sign- or zero-extends them to the full word width.
module lsu_rdata_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  lsu_type_e   type_i,
    input  logic        sign_ext_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        rdata_o = shifted;
        case (type_i)
            LSU_B:   rdata_o = {{24{sign_ext_i & shifted[7]}},  shifted[7:0]};
            LSU_H:   rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: registers one access from issue, runs the request/grant/rvalid
// handshake on the data bus, and returns aligned, extended load data.
//
// state       | meaning
// IDLE        | ready for a new access
// WAIT_GNT    | data_req_o held high until the bus grants
// WAIT_RVALID | waiting for the bus response
// DONE        | single-cycle completion pulse
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  lsu_type_e   lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_rdata_valid_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    lsu_state_e  state_q;
    lsu_type_e   type_q;
    logic        we_q, sign_q, err_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_aligned;
    logic [3:0]  be_q;
    logic        misaligned;

    assign misaligned = lsu_misaligned(lsu_type_i, lsu_addr_i[1:0]);

    lsu_rdata_align u_rdata_align (
        .rdata_i    (data_rdata_i),
        .offset_i   (addr_q[1:0]),
        .type_i     (type_q),
        .sign_ext_i (sign_q),
        .rdata_o    (rdata_aligned)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            type_q  <= LSU_W;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (lsu_req_i) begin
                    type_q  <= lsu_type_i;
                    we_q    <= lsu_we_i;
                    sign_q  <= lsu_sign_ext_i;
                    addr_q  <= lsu_addr_i;
                    wdata_q <= lsu_wdata_i << {lsu_addr_i[1:0], 3'b000};
                    be_q    <= lsu_byte_en(lsu_type_i, lsu_addr_i[1:0]);
                    err_q   <= misaligned;
                    state_q <= misaligned ? DONE : WAIT_GNT;
                end
                WAIT_GNT: if (data_gnt_i) state_q <= WAIT_RVALID;
                WAIT_RVALID: if (data_rvalid_i) begin
                    err_q <= data_err_i;
                    // Result register only moves on a good load so it holds across stores and errors.
                    if (!we_q && !data_err_i) rdata_q <= rdata_aligned;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lsu_ready_o       = rst_ni && (state_q == IDLE);
    assign lsu_done_o        = (state_q == DONE);
    assign lsu_err_o         = (state_q == DONE) && err_q;
    assign lsu_rdata_valid_o = (state_q == DONE) && !err_q && !we_q;
    assign lsu_rdata_o       = rdata_q;

    assign data_req_o   = (state_q == WAIT_GNT);
    assign data_addr_o  = {addr_q[31:2], 2'b00};
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

endmodule
